// File: rtl/ec_montgomery_ladder.sv
// Montgomery-ladder scalar multiplier Q = m*P on y^2 = x^3 + A*x + B over GF(prime), affine coordinates.
// Define MLADDER_SKIP_LEADING_ZEROS_EN to start the ladder at the most significant set bit of m.
module ec_montgomery_ladder #(
  parameter int key_size     = 64,
  parameter int integer_size = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [key_size-1:0]     m,
  input  logic [integer_size-1:0] prime,
  input  logic [integer_size-1:0] A,
  input  logic [integer_size-1:0] B,
  input  logic [integer_size-1:0] Px,
  input  logic [integer_size-1:0] Py,
  output logic                    done,
  output logic                    infinityP,
  output logic [integer_size-1:0] mGx,
  output logic [integer_size-1:0] mGy
);
  localparam int W         = integer_size;
  localparam int K         = key_size;
  localparam int IW        = (K > 1) ? $clog2(K) : 1;
  localparam int CW        = $clog2(2 * W + 1) + 1;
  localparam int INV_ITERS = 2 * W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LADDER = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [2:0] {
    P_SETUP = 3'd0, P_MUL = 3'd1, P_NUM = 3'd2, P_INV = 3'd3,
    P_LAM = 3'd4, P_X3 = 3'd5, P_Y3 = 3'd6
  } phase_t;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    else s = s;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] p);
    return (x >= y) ? (x - y) : (x + (p - y));
  endfunction

  function automatic logic [W-1:0] mod_half(input logic [W-1:0] x, input logic [W-1:0] p);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return s[W:1];
  endfunction

`ifdef MLADDER_SKIP_LEADING_ZEROS_EN
  function automatic logic [IW-1:0] msb_index(input logic [K-1:0] val);
    logic [IW-1:0] r;
    r = {IW{1'b0}};
    for (int k = 0; k < K; k++) begin
      if (val[k]) r = IW'(k);
      else r = r;
    end
    return r;
  endfunction
`endif

  state_t        state_q, state_d;
  phase_t        ph_q, ph_d, ret_q, ret_d;
  logic [K-1:0]  m_q, m_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  p_q, p_d, a_q, a_d;
  logic [W-1:0]  r0x_q, r0x_d, r0y_q, r0y_d, r1x_q, r1x_d, r1y_q, r1y_d, sx_q, sx_d, sy_q, sy_d;
  logic          r0i_q, r0i_d, r1i_q, r1i_d, si_q, si_d, half_q, half_d;
  logic [W-1:0]  ox1_q, ox1_d, oy1_q, oy1_d, ox2_q, ox2_d, oy2_q, oy2_d;
  logic          oi1_q, oi1_d, oi2_q, oi2_d, odbl_q, odbl_d;
  logic [W-1:0]  num_q, num_d, lam_q, lam_d, x3_q, x3_d;
  logic [W-1:0]  ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [W-1:0]  u_q, u_d, v_q, v_d, g1_q, g1_d, g2_q, g2_d;
  logic          done_q, done_d, inf_q, inf_d;
  logic [W-1:0]  gx_q, gx_d, gy_q, gy_d;

  logic          bit_s, sel_i, res_i, nr0_i;
  logic [W-1:0]  sel_x, sel_y, res_x, res_y, nr0_x, nr0_y, x3_s, y3_s;
  logic          b_unused;

  assign b_unused = ^B;

  // State register: every flop clears on reset, otherwise loads its next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  ph_q <= P_SETUP;  ret_q <= P_SETUP;
      m_q <= '0;  idx_q <= '0;  cnt_q <= '0;  p_q <= '0;  a_q <= '0;
      r0x_q <= '0;  r0y_q <= '0;  r0i_q <= 1'b0;  r1x_q <= '0;  r1y_q <= '0;  r1i_q <= 1'b0;
      sx_q <= '0;  sy_q <= '0;  si_q <= 1'b0;  half_q <= 1'b0;
      ox1_q <= '0;  oy1_q <= '0;  ox2_q <= '0;  oy2_q <= '0;
      oi1_q <= 1'b0;  oi2_q <= 1'b0;  odbl_q <= 1'b0;
      num_q <= '0;  lam_q <= '0;  x3_q <= '0;  ma_q <= '0;  mb_q <= '0;  acc_q <= '0;
      u_q <= '0;  v_q <= '0;  g1_q <= '0;  g2_q <= '0;
      done_q <= 1'b0;  inf_q <= 1'b0;  gx_q <= '0;  gy_q <= '0;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;  ret_q <= ret_d;
      m_q <= m_d;  idx_q <= idx_d;  cnt_q <= cnt_d;  p_q <= p_d;  a_q <= a_d;
      r0x_q <= r0x_d;  r0y_q <= r0y_d;  r0i_q <= r0i_d;  r1x_q <= r1x_d;  r1y_q <= r1y_d;  r1i_q <= r1i_d;
      sx_q <= sx_d;  sy_q <= sy_d;  si_q <= si_d;  half_q <= half_d;
      ox1_q <= ox1_d;  oy1_q <= oy1_d;  ox2_q <= ox2_d;  oy2_q <= oy2_d;
      oi1_q <= oi1_d;  oi2_q <= oi2_d;  odbl_q <= odbl_d;
      num_q <= num_d;  lam_q <= lam_d;  x3_q <= x3_d;  ma_q <= ma_d;  mb_q <= mb_d;  acc_q <= acc_d;
      u_q <= u_d;  v_q <= v_d;  g1_q <= g1_d;  g2_q <= g2_d;
      done_q <= done_d;  inf_q <= inf_d;  gx_q <= gx_d;  gy_q <= gy_d;
    end
  end

  // Ladder control and field datapath; every point operation runs the same fixed schedule.
  always_comb begin
    state_d = state_q;  ph_d = ph_q;  ret_d = ret_q;
    m_d = m_q;  idx_d = idx_q;  cnt_d = cnt_q;  p_d = p_q;  a_d = a_q;
    r0x_d = r0x_q;  r0y_d = r0y_q;  r0i_d = r0i_q;  r1x_d = r1x_q;  r1y_d = r1y_q;  r1i_d = r1i_q;
    sx_d = sx_q;  sy_d = sy_q;  si_d = si_q;  half_d = half_q;
    ox1_d = ox1_q;  oy1_d = oy1_q;  ox2_d = ox2_q;  oy2_d = oy2_q;
    oi1_d = oi1_q;  oi2_d = oi2_q;  odbl_d = odbl_q;
    num_d = num_q;  lam_d = lam_q;  x3_d = x3_q;  ma_d = ma_q;  mb_d = mb_q;  acc_d = acc_q;
    u_d = u_q;  v_d = v_q;  g1_d = g1_q;  g2_d = g2_q;
    done_d = done_q;  inf_d = inf_q;  gx_d = gx_q;  gy_d = gy_q;

    bit_s = m_q[idx_q];
    x3_s  = mod_sub(mod_sub(acc_q, ox1_q, p_q), ox2_q, p_q);
    y3_s  = mod_sub(acc_q, oy1_q, p_q);

    // Doubling operand is R1 when the bit is set, otherwise R0 (also the add's first operand).
    if (half_q && bit_s) begin
      sel_x = r1x_q;  sel_y = r1y_q;  sel_i = r1i_q;
    end else begin
      sel_x = r0x_q;  sel_y = r0y_q;  sel_i = r0i_q;
    end

    if (odbl_q) begin
      if (oi1_q || (oy1_q == {W{1'b0}})) begin
        res_x = {W{1'b0}};  res_y = {W{1'b0}};  res_i = 1'b1;
      end else begin
        res_x = x3_q;  res_y = y3_s;  res_i = 1'b0;
      end
    end else if (oi1_q) begin
      res_x = ox2_q;  res_y = oy2_q;  res_i = oi2_q;
    end else if (oi2_q) begin
      res_x = ox1_q;  res_y = oy1_q;  res_i = 1'b0;
    end else if (ox1_q == ox2_q) begin
      res_x = {W{1'b0}};  res_y = {W{1'b0}};  res_i = 1'b1;
    end else begin
      res_x = x3_q;  res_y = y3_s;  res_i = 1'b0;
    end

    if (bit_s) begin
      nr0_x = sx_q;  nr0_y = sy_q;  nr0_i = si_q;
    end else begin
      nr0_x = res_x;  nr0_y = res_y;  nr0_i = res_i;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          m_d = m;  p_d = prime;  a_d = A;
          r0x_d = {W{1'b0}};  r0y_d = {W{1'b0}};  r0i_d = 1'b1;
          r1x_d = Px;  r1y_d = Py;  r1i_d = 1'b0;
          idx_d = IW'(K - 1);  half_d = 1'b0;  ph_d = P_SETUP;
          state_d = S_LADDER;
`ifdef MLADDER_SKIP_LEADING_ZEROS_EN
          idx_d = msb_index(m);
          if (m == {K{1'b0}}) begin
            state_d = S_DONE;  done_d = 1'b1;  inf_d = 1'b1;
            gx_d = {W{1'b0}};  gy_d = {W{1'b0}};
          end else begin
            state_d = S_LADDER;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LADDER: begin
        case (ph_q)
          P_SETUP: begin
            ox1_d = sel_x;  oy1_d = sel_y;  oi1_d = sel_i;
            if (half_q) begin
              ox2_d = sel_x;  oy2_d = sel_y;  oi2_d = sel_i;  odbl_d = 1'b1;
            end else begin
              ox2_d = r1x_q;  oy2_d = r1y_q;  oi2_d = r1i_q;
              odbl_d = !r0i_q && !r1i_q && (r0x_q == r1x_q) && (r0y_q == r1y_q);
            end
            ma_d = sel_x;  mb_d = sel_x;  acc_d = {W{1'b0}};  cnt_d = {CW{1'b0}};
            ret_d = P_NUM;  ph_d = P_MUL;
          end
          P_MUL: begin
            // MSB-first shift-add with the reduction folded into every step.
            if (cnt_q < CW'(W)) begin
              acc_d = mod_add(mod_add(acc_q, acc_q, p_q), mb_q[W-1] ? ma_q : {W{1'b0}}, p_q);
              mb_d  = mb_q << 1;
              cnt_d = cnt_q + CW'(1);
            end else begin
              ph_d = ret_q;
            end
          end
          P_NUM: begin
            if (odbl_q) begin
              num_d = mod_add(mod_add(mod_add(acc_q, acc_q, p_q), acc_q, p_q), a_q, p_q);
              u_d   = mod_add(oy1_q, oy1_q, p_q);
            end else begin
              num_d = mod_sub(oy2_q, oy1_q, p_q);
              u_d   = mod_sub(ox2_q, ox1_q, p_q);
            end
            v_d = p_q;  g1_d = W'(1);  g2_d = {W{1'b0}};  cnt_d = {CW{1'b0}};  ph_d = P_INV;
          end
          P_INV: begin
            // Binary extended Euclid, padded to a fixed cycle count; g1*den = u, g2*den = v.
            if (cnt_q < CW'(INV_ITERS)) begin
              cnt_d = cnt_q + CW'(1);
              if ((u_q == W'(1)) || (v_q == W'(1))) begin
                u_d = u_q;
              end else if (!u_q[0]) begin
                u_d = u_q >> 1;  g1_d = mod_half(g1_q, p_q);
              end else if (!v_q[0]) begin
                v_d = v_q >> 1;  g2_d = mod_half(g2_q, p_q);
              end else if (u_q >= v_q) begin
                u_d = (u_q - v_q) >> 1;  g1_d = mod_half(mod_sub(g1_q, g2_q, p_q), p_q);
              end else begin
                v_d = (v_q - u_q) >> 1;  g2_d = mod_half(mod_sub(g2_q, g1_q, p_q), p_q);
              end
            end else begin
              ma_d = num_q;  mb_d = (u_q == W'(1)) ? g1_q : g2_q;
              acc_d = {W{1'b0}};  cnt_d = {CW{1'b0}};  ret_d = P_LAM;  ph_d = P_MUL;
            end
          end
          P_LAM: begin
            lam_d = acc_q;  ma_d = acc_q;  mb_d = acc_q;
            acc_d = {W{1'b0}};  cnt_d = {CW{1'b0}};  ret_d = P_X3;  ph_d = P_MUL;
          end
          P_X3: begin
            x3_d = x3_s;  ma_d = lam_q;  mb_d = mod_sub(ox1_q, x3_s, p_q);
            acc_d = {W{1'b0}};  cnt_d = {CW{1'b0}};  ret_d = P_Y3;  ph_d = P_MUL;
          end
          P_Y3: begin
            ph_d = P_SETUP;
            if (!half_q) begin
              sx_d = res_x;  sy_d = res_y;  si_d = res_i;  half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              r0x_d = nr0_x;  r0y_d = nr0_y;  r0i_d = nr0_i;
              if (bit_s) begin
                r1x_d = res_x;  r1y_d = res_y;  r1i_d = res_i;
              end else begin
                r1x_d = sx_q;  r1y_d = sy_q;  r1i_d = si_q;
              end
              if (idx_q == {IW{1'b0}}) begin
                state_d = S_DONE;  done_d = 1'b1;  inf_d = nr0_i;  gx_d = nr0_x;  gy_d = nr0_y;
              end else begin
                idx_d = idx_q - IW'(1);
              end
            end
          end
          default: ph_d = P_SETUP;
        endcase
      end
      S_DONE: begin
        if (!go) begin
          state_d = S_IDLE;  done_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done      = done_q;
  assign infinityP = inf_q;
  assign mGx       = gx_q;
  assign mGy       = gy_q;
endmodule

// File: tb/tb_ec_montgomery_ladder.sv
// Directed bench for ec_montgomery_ladder on y^2 = x^3 + 5 mod 7 with P = (3,2), 64-bit scalars.
module tb_ec_montgomery_ladder;
  localparam int KS     = 64;
  localparam int IS     = 4;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst, go;
  logic [KS-1:0] m;
  logic [IS-1:0] prime, a_coef, b_coef, px, py;
  logic          done, inf;
  logic [IS-1:0] gx, gy;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ec_montgomery_ladder #(.key_size(KS), .integer_size(IS)) dut (
    .clk(clk), .rst(rst), .go(go), .m(m), .prime(prime), .A(a_coef), .B(b_coef),
    .Px(px), .Py(py), .done(done), .infinityP(inf), .mGx(gx), .mGy(gy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [KS-1:0] mv);
    @(negedge clk);
    m  = mv;
    go = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic run_case(input string tag, input logic [KS-1:0] mv, input logic [IS-1:0] ex,
                          input logic [IS-1:0] ey, input logic ei, output int lat);
    start(mv);
    wait_done(tag, lat);
    check({tag, "_x"}, gx, ex);
    check({tag, "_y"}, gy, ey);
    check({tag, "_inf"}, inf, ei);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, done, 1'b0);
  endtask

  initial begin
    int lat1, lat63, lat_tmp;
    rst = 1'b1;  go = 1'b0;  m = '0;
    prime = 4'd7;  a_coef = 4'd0;  b_coef = 4'd5;  px = 4'd3;  py = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b0);
    check("rst_inf", inf, 1'b0);
    check("rst_x", gx, 4'd0);
    check("rst_y", gy, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // m=3 with go held high: done must stay asserted and outputs stable.
    start(64'd3);
    wait_done("m3", lat_tmp);
    check("m3_x", gx, 4'd6);
    check("m3_y", gy, 4'd5);
    check("m3_inf", inf, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("m3_hold_done", done, 1'b1);
    check("m3_hold_x", gx, 4'd6);

    // Restart: go low for one cycle, then a new start with m=2.
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("restart_done_fall", done, 1'b0);
    check("restart_x_kept", gx, 4'd6);
    start(64'd2);
    wait_done("m2", lat_tmp);
    check("m2_x", gx, 4'd5);
    check("m2_y", gy, 4'd2);
    check("m2_inf", inf, 1'b0);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);

    // Reset in the middle of a ladder run.
    start(64'd6);
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_inf", inf, 1'b0);
    check("mid_rst_x", gx, 4'd0);
    check("mid_rst_y", gy, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    go  = 1'b0;
    run_case("after_rst_m3", 64'd3, 4'd6, 4'd5, 1'b0, lat_tmp);

    run_case("m1", 64'd1, 4'd3, 4'd2, 1'b0, lat1);
    run_case("m4", 64'd4, 4'd6, 4'd2, 1'b0, lat_tmp);
    run_case("m6", 64'd6, 4'd3, 4'd5, 1'b0, lat_tmp);
    run_case("m7", 64'd7, 4'd0, 4'd0, 1'b1, lat_tmp);
    run_case("m0", 64'd0, 4'd0, 4'd0, 1'b1, lat_tmp);
    // 2^63 = (2^3)^21 = 1 mod 7, so the result is P itself.
    run_case("m2p63", 64'h8000_0000_0000_0000, 4'd3, 4'd2, 1'b0, lat63);

`ifdef MLADDER_SKIP_LEADING_ZEROS_EN
    checks++;
    assert (lat1 < lat63) else begin
      errors++;
      $error("FAIL lat_skip: m=1 took %0d cycles, m=2^63 took %0d, required m=1 faster", lat1, lat63);
    end
`else
    check("lat_const", lat1, lat63);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
